regfile_mp: RTL and testbench

Parametrised multi-port register file with an integrated busy scoreboard, the next-generation register storage for the pipelined CPU.
- Provides NUM_RD combinational read ports and two prioritised write ports: port 0 for ALU writeback, port 1 for load writeback.
- Register 0 is hardwired to zero.
- Write-to-read bypass is optional.
- A per-register busy bit is set at issue and cleared at writeback, so decode can detect RAW hazards on in-flight results.

---
 rtl/regfile_mp.sv | 135 +++++++++++++
 tb/tb_regfile_mp.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port register file with a per-register busy scoreboard.
//
// Storage is DEPTH = 2**ADDR_W registers of DATA_W bits; register 0 always
// reads zero and ignores writes. Two write ports share the array, and port 1
// (load writeback) wins over port 0 (ALU writeback) on an address collision.
// NUM_RD (1..4) combinational read ports each return data plus the registered
// busy bit of the addressed register.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   -> a same-cycle write is forwarded to matching read ports
//                (port 1 ahead of port 0, the same priority as the write).
//   undefined -> reads always return the stored value.
//   rd_busy never forwards a same-cycle clear in either build.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rd_addr / rd_data     packed read addresses / data, port k at slice k
//   rd_busy               busy bit of each addressed register
//   wr0_* / wr1_*         write ports (1 has priority)
//   iss_en / iss_addr     issue strobe marking iss_addr as pending
//   busy                  registered scoreboard vector, bit 0 always 0

// One read port: register select, optional forwarding, zero for address 0.
module regfile_mp_rd #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] regs,
    input  logic [DEPTH-1:0]             busy,
    input  logic [ADDR_W-1:0]            addr,
`ifdef RF_BYPASS_EN
    input  logic                         wr0_en,
    input  logic [ADDR_W-1:0]            wr0_addr,
    input  logic [DATA_W-1:0]            wr0_data,
    input  logic                         wr1_en,
    input  logic [ADDR_W-1:0]            wr1_addr,
    input  logic [DATA_W-1:0]            wr1_data,
`endif
    output logic [DATA_W-1:0]            data,
    output logic                         rd_busy
);
    always_comb begin
        data = regs[addr];
`ifdef RF_BYPASS_EN
        if (wr1_en && wr1_addr == addr)
            data = wr1_data;
        else if (wr0_en && wr0_addr == addr)
            data = wr0_data;
`endif
        // Address 0 is zero even when a write to it is in flight.
        if (addr == '0)
            data = '0;
        // Registered value only: a writeback this cycle still reads as busy.
        rd_busy = busy[addr];
    end
endmodule

module regfile_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [(2**ADDR_W)-1:0]     busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             busy_q;
    logic [DEPTH-1:0]             busy_nxt;

    // Scoreboard update: clears first, then the issue set, so a new producer
    // overrides a completing one on the same register.
    always_comb begin
        busy_nxt = busy_q;
        if (wr0_en)
            busy_nxt[wr0_addr] = 1'b0;
        if (wr1_en)
            busy_nxt[wr1_addr] = 1'b0;
        if (iss_en)
            busy_nxt[iss_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Port 1 is written after port 0 so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs   <= '0;
            busy_q <= '0;
        end else begin
            if (wr0_en && wr0_addr != '0)
                regs[wr0_addr] <= wr0_data;
            if (wr1_en && wr1_addr != '0)
                regs[wr1_addr] <= wr1_data;
            busy_q <= busy_nxt;
        end
    end

    assign busy = busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_mp_rd #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_rd (
            .regs     (regs),
            .busy     (busy_q),
            .addr     (rd_addr[k*ADDR_W +: ADDR_W]),
`ifdef RF_BYPASS_EN
            .wr0_en   (wr0_en),
            .wr0_addr (wr0_addr),
            .wr0_data (wr0_data),
            .wr1_en   (wr1_en),
            .wr1_addr (wr1_addr),
            .wr1_data (wr1_data),
`endif
            .data     (rd_data[k*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[k])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- directed test of regfile_mp (DATA_W=16, ADDR_W=4, NUM_RD=2).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 unit later, well before the next edge commits state.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr0_en, wr1_en, iss_en;
    logic [3:0]  wr0_addr, wr1_addr, iss_addr;
    logic [15:0] wr0_data, wr1_data;
    logic [15:0] busy;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
        .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
        .wr1_data(wr1_data), .iss_en(iss_en), .iss_addr(iss_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 0; wr0_addr = 0; wr0_data = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0;
        iss_en = 0; iss_addr = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); rd_addr = 8'h00;
        wr0_en = 1; wr0_addr = 4'd3; wr0_data = 16'hBEEF;
        tick(); tick();
        rst = 0; idle(); rd_addr = 8'h03;
        #1;
        checks++; if (rd_data[15:0] !== 16'h0000) begin errors++;
            $display("FAIL reset_rd3 got %h exp 0000", rd_data[15:0]); end
        checks++; if (busy !== 16'h0000) begin errors++;
            $display("FAIL reset_busy got %h exp 0000", busy); end
        checks++; if (rd_busy !== 2'b00) begin errors++;
            $display("FAIL reset_rd_busy got %b exp 00", rd_busy); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = {4'(a), 4'(a)};
            #1;
            checks++; if (rd_data !== 32'h0) begin errors++;
                $display("FAIL reset_all addr %0d got %h exp 0", a, rd_data); end
        end
    endtask

    task automatic test_reg0();
        idle(); rd_addr = 8'h00;
        wr0_en = 1; wr0_addr = 0; wr0_data = 16'h1234;
        wr1_en = 1; wr1_addr = 0; wr1_data = 16'h1234;
        iss_en = 1; iss_addr = 0;
        #1;
        checks++; if (rd_data[15:0] !== 16'h0000) begin errors++;
            $display("FAIL reg0_same_cycle got %h exp 0000", rd_data[15:0]); end
        tick(); idle();
        #1;
        checks++; if (rd_data !== 32'h0) begin errors++;
            $display("FAIL reg0_read got %h exp 0", rd_data); end
        checks++; if (busy !== 16'h0000) begin errors++;
            $display("FAIL reg0_busy got %h exp 0000", busy); end
    endtask

    task automatic test_collision();
        idle();
        wr0_en = 1; wr0_addr = 4'd5; wr0_data = 16'hAAAA;
        wr1_en = 1; wr1_addr = 4'd5; wr1_data = 16'h5555;
        tick(); idle(); rd_addr = 8'h05;
        #1;
        checks++; if (rd_data[15:0] !== 16'h5555) begin errors++;
            $display("FAIL collision got %h exp 5555", rd_data[15:0]); end
        wr0_en = 1; wr0_addr = 4'd6; wr0_data = 16'h1111;
        wr1_en = 1; wr1_addr = 4'd8; wr1_data = 16'h2222;
        tick(); idle(); rd_addr = 8'h86;
        #1;
        checks++; if (rd_data !== 32'h2222_1111) begin errors++;
            $display("FAIL indep_write got %h exp 22221111", rd_data); end
    endtask

    task automatic test_bypass();
        idle();
        wr0_en = 1; wr0_addr = 4'd7; wr0_data = 16'h0101;
        tick(); idle(); rd_addr = 8'h77;
        wr0_en = 1; wr0_addr = 4'd7; wr0_data = 16'hCAFE;
        #1;
`ifdef RF_BYPASS_EN
        checks++; if (rd_data !== 32'hCAFE_CAFE) begin errors++;
            $display("FAIL bypass_same got %h exp CAFECAFE", rd_data); end
`else
        checks++; if (rd_data !== 32'h0101_0101) begin errors++;
            $display("FAIL nobypass_same got %h exp 01010101", rd_data); end
`endif
        tick(); idle();
        #1;
        checks++; if (rd_data !== 32'hCAFE_CAFE) begin errors++;
            $display("FAIL bypass_after got %h exp CAFECAFE", rd_data); end
        // Both ports target the register being read: port 1 data expected.
        wr0_en = 1; wr0_addr = 4'd7; wr0_data = 16'h00A0;
        wr1_en = 1; wr1_addr = 4'd7; wr1_data = 16'h00B1;
        #1;
`ifdef RF_BYPASS_EN
        checks++; if (rd_data[15:0] !== 16'h00B1) begin errors++;
            $display("FAIL bypass_prio got %h exp 00B1", rd_data[15:0]); end
`else
        checks++; if (rd_data[15:0] !== 16'hCAFE) begin errors++;
            $display("FAIL nobypass_prio got %h exp CAFE", rd_data[15:0]); end
`endif
        tick(); idle();
        // Address 0 never forwards.
        rd_addr = 8'h00;
        wr1_en = 1; wr1_addr = 0; wr1_data = 16'hFFFF;
        #1;
        checks++; if (rd_data !== 32'h0) begin errors++;
            $display("FAIL bypass_reg0 got %h exp 0", rd_data); end
        tick(); idle();
    endtask

    task automatic test_scoreboard();
        idle();
        iss_en = 1; iss_addr = 4'd9;
        tick(); idle(); rd_addr = 8'h09;
        #1;
        checks++; if (busy !== 16'h0200) begin errors++;
            $display("FAIL sb_set got %h exp 0200", busy); end
        checks++; if (rd_busy !== 2'b01) begin errors++;
            $display("FAIL sb_rd_busy got %b exp 01", rd_busy); end
        wr1_en = 1; wr1_addr = 4'd9; wr1_data = 16'h0999;
        #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++;
            $display("FAIL sb_no_bypass_clear got %b exp 1", rd_busy[0]); end
        tick(); idle();
        #1;
        checks++; if (busy !== 16'h0000) begin errors++;
            $display("FAIL sb_clear got %h exp 0000", busy); end
        checks++; if (rd_busy !== 2'b00) begin errors++;
            $display("FAIL sb_rd_busy_clear got %b exp 00", rd_busy); end
    endtask

    task automatic test_race();
        idle();
        iss_en = 1; iss_addr = 4'd4;
        tick(); idle();
        #1;
        checks++; if (busy !== 16'h0010) begin errors++;
            $display("FAIL race_pre got %h exp 0010", busy); end
        iss_en = 1; iss_addr = 4'd4;
        wr0_en = 1; wr0_addr = 4'd4; wr0_data = 16'h0042;
        tick(); idle(); rd_addr = 8'h04;
        #1;
        checks++; if (busy !== 16'h0010) begin errors++;
            $display("FAIL race_busy got %h exp 0010", busy); end
        checks++; if (rd_data[15:0] !== 16'h0042) begin errors++;
            $display("FAIL race_data got %h exp 0042", rd_data[15:0]); end
    endtask

    task automatic test_mid_reset();
        idle();
        iss_en = 1; iss_addr = 4'd10;
        tick(); idle();
        rst = 1;
        wr0_en = 1; wr0_addr = 4'd10; wr0_data = 16'h7777;
        iss_en = 1; iss_addr = 4'd11;
        tick(); rst = 0; idle(); rd_addr = 8'h5A;
        #1;
        checks++; if (busy !== 16'h0000) begin errors++;
            $display("FAIL midrst_busy got %h exp 0000", busy); end
        checks++; if (rd_data !== 32'h0) begin errors++;
            $display("FAIL midrst_data got %h exp 0", rd_data); end
        wr0_en = 1; wr0_addr = 4'd11; wr0_data = 16'h1B1B;
        iss_en = 1; iss_addr = 4'd12;
        tick(); idle(); rd_addr = 8'hCB;
        #1;
        checks++; if (rd_data[15:0] !== 16'h1B1B) begin errors++;
            $display("FAIL postrst_write got %h exp 1B1B", rd_data[15:0]); end
        checks++; if (busy !== 16'h1000 || rd_busy !== 2'b10) begin errors++;
            $display("FAIL postrst_issue got %h/%b exp 1000/10", busy, rd_busy); end
    endtask

    initial begin
        test_reset();
        test_reg0();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_race();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
